halfword_store_unit: RTL and testbench



---
 rtl/halfword_store_unit.sv | 127 ++++++++++++
 tb/tb_halfword_store_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/halfword_store_unit.sv
// Narrowing store path: writes the low byte or halfword of a 32-bit value into a
// word-wide synchronous memory by read-modify-write, flagging signed overflow.
module halfword_store_unit #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic              req_size,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              done,
    output logic              ovf,
    output logic              misaligned
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RSP
    } state_t;

    state_t      state;
    logic [1:0]  lane_q;
    logic        size_q;
    logic [31:0] data_q;
    logic        req_misaligned;
    logic        narrow_ovf;
    logic [31:0] merged;

    assign req_misaligned = req_size & req_addr[0];

    // The value fits iff every discarded upper bit equals the new sign bit.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        narrow_ovf = 1'b0;
        if (size_q) begin
            narrow_ovf = !((&data_q[31:15]) || (~|data_q[31:15]));
        end else begin
            narrow_ovf = !((&data_q[31:7]) || (~|data_q[31:7]));
        end
    end

    always_comb begin
        merged = mem_rdata;
        if (size_q) begin
            if (lane_q[1]) begin
                merged[31:16] = data_q[15:0];
            end else begin
                merged[15:0] = data_q[15:0];
            end
        end else begin
            unique case (lane_q)
                2'd0: merged[7:0]   = data_q[7:0];
                2'd1: merged[15:8]  = data_q[7:0];
                2'd2: merged[23:16] = data_q[7:0];
                2'd3: merged[31:24] = data_q[7:0];
            endcase
        end
    end

    // Read data only exists during WR, so the write word is merged combinationally there.
    assign mem_wdata = (state == WR) ? merged : 32'd0;

    // NOTE: payload registers carry no reset; they are always loaded before being read.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            lane_q <= req_addr[1:0];
            size_q <= req_size;
            data_q <= req_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            done       <= 1'b0;
            ovf        <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (req_misaligned) begin
                            state      <= RSP;
                            done       <= 1'b1;
                            misaligned <= 1'b1;
                            ovf        <= 1'b0;
                        end else begin
                            state    <= RD;
                            mem_addr <= req_addr[ADDR_W+1:2];
                        end
                    end
                end
                RD: begin
                    state  <= WR;
                    mem_we <= 1'b1;
                end
                WR: begin
                    state  <= RSP;
                    mem_we <= 1'b0;
                    done   <= 1'b1;
                    ovf    <= narrow_ovf;
                end
                RSP: begin
                    state      <= IDLE;
                    done       <= 1'b0;
                    ovf        <= 1'b0;
                    misaligned <= 1'b0;
                    req_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_halfword_store_unit.sv
// Bench for halfword_store_unit: behavioural memory, a cycle-level reference model
// compared every cycle, and directed stores with hand-computed results.
module tb_halfword_store_unit;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W+1:0] req_addr = '0;
    logic [31:0]       req_data = '0;
    logic              req_size = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic              done;
    logic              ovf;
    logic              misaligned;

    halfword_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_size   (req_size),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .done       (done),
        .ovf        (ovf),
        .misaligned (misaligned)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memory with a bench-side preload port.
    logic [31:0]       mem [256];
    logic              pl_we = 1'b0;
    logic [ADDR_W-1:0] pl_addr = '0;
    logic [31:0]       pl_data = '0;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (pl_we) mem[pl_addr] <= pl_data;
        mem_rdata <= mem[mem_addr];
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference rules expressed arithmetically.
    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [9:0] a,
                                                input logic sz, input logic [31:0] d);
        logic [31:0] r;
        int off;
        r = old;
        if (sz) begin
            off = a[1] ? 16 : 0;
            r[off +: 16] = d[15:0];
        end else begin
            off = 8 * int'(a[1:0]);
            r[off +: 8] = d[7:0];
        end
        return r;
    endfunction

    function automatic logic model_ovf(input logic [31:0] d, input logic sz);
        int v;
        v = $signed(d);
        if (sz) return (v < -32768) || (v > 32767);
        return (v < -128) || (v > 127);
    endfunction

    // Cycle-level model: one outstanding store, events scheduled by cycle number.
    logic       act = 1'b0;
    int         t_we = -10;
    int         t_done = -10;
    logic [9:0] m_addr;
    logic [31:0] m_data;
    logic       m_size;
    logic       m_mis;
    logic       prev_rst = 1'b0;

    always @(negedge clk) begin
        if (cyc >= 2) begin
            if (prev_rst) begin
                check("rst_ready", req_ready, 1);
                check("rst_we", mem_we, 0);
                check("rst_addr", mem_addr, 0);
                check("rst_wdata", mem_wdata, 0);
                check("rst_done", done, 0);
                check("rst_ovf", ovf, 0);
                check("rst_mis", misaligned, 0);
            end
            check("ready", req_ready, !act);
            check("we", mem_we, act && cyc == t_we);
            check("done", done, act && cyc == t_done);
            if (act && !m_mis && (cyc == t_we - 1 || cyc == t_we))
                check("mem_addr", mem_addr, m_addr[9:2]);
            if (act && cyc == t_we)
                check("wdata", mem_wdata, model_merge(mem[m_addr[9:2]], m_addr, m_size, m_data));
            if (act && cyc == t_done) begin
                check("ovf", ovf, m_mis ? 1'b0 : model_ovf(m_data, m_size));
                check("misaligned", misaligned, m_mis);
            end
        end
        if (rst) begin
            act = 1'b0;
        end else if (act && cyc == t_done) begin
            act = 1'b0;
        end else if (!act && req_valid) begin
            act    = 1'b1;
            m_addr = req_addr;
            m_data = req_data;
            m_size = req_size;
            m_mis  = req_size && req_addr[0];
            t_we   = m_mis ? -10 : cyc + 2;
            t_done = m_mis ? cyc + 1 : cyc + 3;
        end
        prev_rst = rst;
    end

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    task automatic do_store(input logic [9:0] a, input logic [31:0] d, input logic sz,
                            input logic [31:0] exp_word, input logic exp_ovf, input logic exp_mis);
        int lat;
        lat = 0;
        @(posedge clk); #1;
        check("ready_before", req_ready, 1);
        req_valid = 1'b1; req_addr = a; req_data = d; req_size = sz;
        @(posedge clk); #1;
        req_valid = 1'b0; req_data = 32'hDEADBEEF;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                check("ovf_lit", ovf, exp_ovf);
                check("mis_lit", misaligned, exp_mis);
            end
        end
        check("latency", lat, exp_mis ? 1 : 3);
        check("word_lit", mem[a[9:2]], exp_word);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        check("model_merge_pin", model_merge(32'hAABBCCDD, 10'h06, 1'b1, 32'hFFFF8001), 32'h8001CCDD);
        check("model_merge_pin2", model_merge(32'hAABBCCDD, 10'h05, 1'b0, 32'h00000123), 32'hAABB23DD);
        check("model_ovf_pin", model_ovf(32'h00008000, 1'b1), 1);
        check("model_ovf_pin2", model_ovf(32'hFFFFFF80, 1'b0), 0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Word-1 sequence covering all lanes, both sizes and overflow edges.
        preload(8'd1, 32'hAABBCCDD);
        do_store(10'h006, 32'hFFFF8001, 1'b1, 32'h8001CCDD, 1'b0, 1'b0);
        preload(8'd1, 32'hAABBCCDD);
        do_store(10'h005, 32'h00000123, 1'b0, 32'hAABB23DD, 1'b1, 1'b0);
        do_store(10'h004, 32'hFFFFFF80, 1'b0, 32'hAABB2380, 1'b0, 1'b0);
        do_store(10'h004, 32'h00007FFF, 1'b1, 32'hAABB7FFF, 1'b0, 1'b0);
        do_store(10'h004, 32'h00008000, 1'b1, 32'hAABB8000, 1'b1, 1'b0);
        do_store(10'h007, 32'hFFFFFF00, 1'b0, 32'h00BB8000, 1'b1, 1'b0);

        // Byte at an odd address is legal; halfword there is misaligned.
        preload(8'd0, 32'h01020304);
        do_store(10'h003, 32'hFFFFFFEE, 1'b0, 32'hEE020304, 1'b0, 1'b0);
        do_store(10'h003, 32'h00001234, 1'b1, 32'hEE020304, 1'b0, 1'b1);

        // Reset during RD drops the store.
        preload(8'd2, 32'hCAFEF00D);
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = 10'h008; req_data = 32'h12345678; req_size = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rd_rst_no_done", done, 0);
            check("rd_rst_no_we", mem_we, 0);
        end
        check("rd_rst_word", mem[2], 32'hCAFEF00D);
        check("rd_rst_ready", req_ready, 1);

        // Reset during WR still lets the write land but suppresses done.
        preload(8'd3, 32'h55667788);
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = 10'h00D; req_data = 32'h000000AB; req_size = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("wr_rst_no_done", done, 0);
        end
        check("wr_rst_word", mem[3], 32'h5566AB88);

        // Back-to-back stores with req_valid held high; the second merges on the first.
        preload(8'd4, 32'h11223344);
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = 10'h010; req_data = 32'h00000055; req_size = 1'b0;
        @(posedge clk); #1;
        req_addr = 10'h012; req_data = 32'hFFFFBEEF; req_size = 1'b1;
        repeat (4) @(negedge clk);
        check("hold_ready_t4", req_ready, 1);
        check("hold_first_word", mem[4], 32'h11223355);
        @(negedge clk);
        check("hold_busy_t5", req_ready, 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_final_word", mem[4], 32'hBEEF3355);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
